// File: rtl/ha_array_accum_seq.sv
// Sequential accumulator for the four rows of an approximate 8x8 HA-array multiplier.
// One row is folded into a 17-bit accumulator per cycle through a single shared adder.
module ha_array_accum_seq #(
    parameter int SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        k_q;
    logic [16:0]       acc_q;
    logic [3:0][8:0]   t_q;
    logic [3:0][6:0]   b_q;

    logic [8:0]        sel_t;
    logic [6:0]        sel_b;
    logic [9:0]        row;
    logic [16:0]       addend;
    logic [16:0]       acc_sum;

    // Row k is selected from the operand register, weighted by 2^(2k), then added.
    assign sel_t   = t_q[k_q];
    assign sel_b   = b_q[k_q];
    assign row     = {1'b0, sel_t} + {1'b0, sel_b, 2'b00};
    assign addend  = {7'd0, row} << {k_q, 1'b0};
    assign acc_sum = acc_q + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (k_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= 2'd0;
            acc_q <= 17'd0;
            t_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        t_q   <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
                        b_q   <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
                        acc_q <= 17'd0;
                        k_q   <= 2'd0;
                    end
                end
                ACC: begin
                    acc_q <= acc_sum;
                    // k parks at 3 so the final row is never revisited without a new accept.
                    if (k_q != 2'd3) begin
                        k_q <= k_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ovf     = acc_q[16];
    assign product = ((SAT_EN != 0) && acc_q[16]) ? 16'hFFFF : acc_q[15:0];

endmodule

// File: tb/tb_ha_array_accum_seq.sv
// Self-checking bench for ha_array_accum_seq; a saturating and a wrapping instance share stimulus
// and are compared against a bit-weight reference model.
module tb_ha_array_accum_seq;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [3:0][8:0] t_in;
    logic [3:0][6:0] b_in;

    logic            in_ready_s, out_valid_s, ovf_s;
    logic [15:0]     product_s;
    logic            in_ready_w, out_valid_w, ovf_w;
    logic [15:0]     product_w;

    int total = 0;
    int bad   = 0;

    ha_array_accum_seq #(.SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]), .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
        .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]), .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid_s), .out_ready(out_ready), .product(product_s), .ovf(ovf_s)
    );

    ha_array_accum_seq #(.SAT_EN(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]), .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
        .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]), .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid_w), .out_ready(out_ready), .product(product_w), .ovf(ovf_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: every set bit contributes its weight 2^(2k+j) (sum rows) or 2^(2k+j+2) (carry rows).
    function automatic int model(input logic [3:0][8:0] tt, input logic [3:0][6:0] bb);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 9; j++) if (tt[k][j]) s += 1 << (2 * k + j);
            for (int j = 0; j < 7; j++) if (bb[k][j]) s += 1 << (2 * k + j + 2);
        end
        return s;
    endfunction

    function automatic logic [15:0] exp_sat(input int s);
        return (s > 65535) ? 16'hFFFF : s[15:0];
    endfunction

    task automatic randomize_inputs();
        for (int k = 0; k < 4; k++) begin
            t_in[k] = 9'($urandom);
            b_in[k] = 7'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        randomize_inputs();
        #12;
        total++;
        if ({out_valid_s, out_valid_w, in_ready_s, in_ready_w} !== 4'b0011) begin
            bad++;
            $display("[TB] FAIL reset_handshake: got %b expected 0011",
                     {out_valid_s, out_valid_w, in_ready_s, in_ready_w});
        end
        total++;
        if ({product_s, product_w, ovf_s, ovf_w} !== 34'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got ps=%h pw=%h ovf=%b%b expected zeros",
                     product_s, product_w, ovf_s, ovf_w);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // One full transaction with out_ready held low until the result is presented.
    task automatic run_one(input string name, input logic [3:0][8:0] tt, input logic [3:0][6:0] bb);
        int s;
        s         = model(tt, bb);
        t_in      = tt;
        b_in      = bb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready_s !== 1'b0 || out_valid_s !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_accept: got in_ready=%b out_valid=%b expected 0 0", name, in_ready_s, out_valid_s);
        end
        in_valid = 1'b0;
        randomize_inputs();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid_s !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_early_valid: got out_valid=%b after 3 edges expected 0", name, out_valid_s);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid_s !== 1'b1 || out_valid_w !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_valid: got %b%b after 4 edges expected 11", name, out_valid_s, out_valid_w);
        end
        total++;
        if (product_s !== exp_sat(s) || ovf_s !== (s > 65535)) begin
            bad++;
            $display("[TB] FAIL %s_sat: got product=%h ovf=%b expected product=%h ovf=%b",
                     name, product_s, ovf_s, exp_sat(s), (s > 65535));
        end
        total++;
        if (product_w !== s[15:0] || ovf_w !== (s > 65535)) begin
            bad++;
            $display("[TB] FAIL %s_wrap: got product=%h ovf=%b expected product=%h ovf=%b",
                     name, product_w, ovf_w, s[15:0], (s > 65535));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_release: got out_valid=%b in_ready=%b expected 0 1", name, out_valid_s, in_ready_s);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0][8:0] tt;
        logic [3:0][6:0] bb;
        tt = '0; bb = '0;
        run_one("zeros", tt, bb);
        tt = '0; bb = '0; tt[0] = 9'h001;
        run_one("t0_lsb", tt, bb);
        tt = '0; bb = '0; tt[3] = 9'h1FF;
        run_one("t3_full", tt, bb);
        tt = '0; bb = '0; bb[2] = 7'h01;
        run_one("b2_lsb", tt, bb);
        tt = '1; bb = '1;
        run_one("all_ones", tt, bb);
        total++;
        if (product_s !== 16'hFFFF || product_w !== 16'h5257 || ovf_s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL all_ones_hold: got ps=%h pw=%h ovf=%b expected FFFF 5257 1", product_s, product_w, ovf_s);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0][8:0] tt, nt;
        logic [3:0][6:0] bb, nb;
        int s_old, s_new;
        for (int k = 0; k < 4; k++) begin
            tt[k] = 9'($urandom); bb[k] = 7'($urandom);
            nt[k] = 9'($urandom); nb[k] = 7'($urandom);
        end
        s_old = model(tt, bb);
        s_new = model(nt, nb);
        t_in = tt; b_in = bb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        t_in = nt; b_in = nb;
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (in_ready_s !== 1'b0 || out_valid_s !== 1'b1 || product_s !== exp_sat(s_old)) begin
                bad++;
                $display("[TB] FAIL bp_hold_%0d: got in_ready=%b out_valid=%b product=%h expected 0 1 %h",
                         c, in_ready_s, out_valid_s, product_s, exp_sat(s_old));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid_s, in_ready_s);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready_s !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_accept_new: got in_ready=%b expected 0", in_ready_s);
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out_valid_s !== 1'b1 || product_s !== exp_sat(s_new) || product_w !== s_new[15:0]) begin
            bad++;
            $display("[TB] FAIL bp_new_result: got valid=%b ps=%h pw=%h expected 1 %h %h",
                     out_valid_s, product_s, product_w, exp_sat(s_new), s_new[15:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_acc();
        logic [3:0][8:0] tt;
        logic [3:0][6:0] bb;
        int seen;
        randomize_inputs();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid_s, in_ready_s, ovf_s, ovf_w} !== 4'b0100 || product_s !== 16'd0 || product_w !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midacc_reset: got valid=%b ready=%b ovf=%b%b ps=%h pw=%h expected 0 1 00 0 0",
                     out_valid_s, in_ready_s, ovf_s, ovf_w, product_s, product_w);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_s || out_valid_w) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL midacc_no_valid: got %0d valid cycles expected 0", seen);
        end
        for (int k = 0; k < 4; k++) begin
            tt[k] = 9'($urandom); bb[k] = 7'($urandom);
        end
        run_one("post_reset", tt, bb);
    endtask

    // out_ready held high and in_valid held high: a new accept every 6 edges.
    task automatic test_back_to_back();
        logic [3:0][8:0] cur_t, nxt_t;
        logic [3:0][6:0] cur_b, nxt_b;
        int s;
        for (int k = 0; k < 4; k++) begin
            cur_t[k] = 9'($urandom); cur_b[k] = 7'($urandom);
        end
        t_in = cur_t; b_in = cur_b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            s = model(cur_t, cur_b);
            @(posedge clk); #1;
            total++;
            if (in_ready_s !== 1'b0) begin
                bad++;
                $display("[TB] FAIL b2b_accept_%0d: got in_ready=%b expected 0", n, in_ready_s);
            end
            for (int k = 0; k < 4; k++) begin
                nxt_t[k] = (n % 4 == 1) ? 9'h1FF : 9'($urandom);
                nxt_b[k] = (n % 4 == 1) ? 7'h7F  : 7'($urandom);
            end
            t_in = nxt_t; b_in = nxt_b;
            if (n == 11) in_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            total++;
            if (out_valid_s !== 1'b1 || product_s !== exp_sat(s) || product_w !== s[15:0] || ovf_w !== (s > 65535)) begin
                bad++;
                $display("[TB] FAIL b2b_result_%0d: got valid=%b ps=%h pw=%h ovf=%b expected 1 %h %h %b",
                         n, out_valid_s, product_s, product_w, ovf_w, exp_sat(s), s[15:0], (s > 65535));
            end
            @(posedge clk); #1;
            total++;
            if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_idle_%0d: got valid=%b ready=%b expected 0 1", n, out_valid_s, in_ready_s);
            end
            cur_t = nxt_t; cur_b = nxt_b;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_acc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
